// File: rtl/grid_pkg.sv
// rtl/grid_pkg.sv - shared constants, types and row helpers for the LED grid scanner
package grid_pkg;

  localparam int ROWS  = 16;
  localparam int COLS  = 16;
  localparam int ROW_W = $clog2(ROWS);

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} scan_state_t;

  typedef logic [ROWS*COLS-1:0] grid_t;

  // Row 0 is the MSB slice of a generation; bit COLS-1 of a row is the leftmost column.
  function automatic logic [COLS-1:0] row_slice(input grid_t g, input logic [ROW_W-1:0] r);
    return g[(ROWS-1-int'(r))*COLS +: COLS];
  endfunction

  function automatic logic [ROWS-1:0] row_onehot(input logic [ROW_W-1:0] r);
    return ROWS'(1) << r;
  endfunction

endpackage

// File: rtl/grid_scan_if.sv
// rtl/grid_scan_if.sv - generation handoff from the life-grid generator
interface grid_scan_if;
  import grid_pkg::*;

  grid_t grid_in;
  logic  grid_valid;
  logic  grid_ready;

  modport master (output grid_in, output grid_valid, input grid_ready);
  modport slave  (input grid_in, input grid_valid, output grid_ready);

endinterface

// File: rtl/grid_frame_buf.sv
// rtl/grid_frame_buf.sv - pending/display double buffer with generation counter
module grid_frame_buf
  import grid_pkg::*;
#(
  parameter logic [15:0] GEN_MAX = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  grid_scan_if.slave  gif,
  input  logic        swap_ok,
  output grid_t       display,
  output logic [15:0] gen_count
);

  grid_t pending;
  logic  pending_full;
  logic  swap;
  logic  load;

  // A swap needs a whole generation waiting; a load needs the pending slot free.
  assign swap           = swap_ok && pending_full;
  assign load           = gif.grid_valid && !pending_full;
  assign gif.grid_ready = !pending_full;

  // Swap is applied before load so a refill never overwrites the generation being shown next.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending      <= '0;
      display      <= '0;
      pending_full <= 1'b0;
      gen_count    <= '0;
    end else begin
      if (swap) begin
        display   <= pending;
        gen_count <= (gen_count == GEN_MAX) ? 16'd0 : gen_count + 16'd1;
      end
      if (load) begin
        pending      <= gif.grid_in;
        pending_full <= 1'b1;
      end else if (swap) begin
        pending_full <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/grid_scan.sv
// rtl/grid_scan.sv - row-scanned 16x16 LED matrix driver with tear-free frame swap
module grid_scan
  import grid_pkg::*;
#(
  parameter int          DWELL   = 1000,
  parameter int          BLANK   = 2,
  parameter logic [15:0] GEN_MAX = 16'hFFFF
) (
  input  logic            clk,
  input  logic            reset,
  grid_scan_if.slave      gif,
  input  logic            enable,
  output logic [ROWS-1:0] row_sel,
  output logic [COLS-1:0] col_data,
  output logic            frame_done,
  output logic [15:0]     gen_count
);

  localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ROWS - 1);

  scan_state_t      state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [ROW_W-1:0] row, row_n;
  logic             frame_end;
  logic             swap_ok;
  grid_t            display;

  grid_frame_buf #(.GEN_MAX(GEN_MAX)) u_buf (
    .clk       (clk),
    .reset     (reset),
    .gif       (gif),
    .swap_ok   (swap_ok),
    .display   (display),
    .gen_count (gen_count)
  );

  // State, phase counter and row index registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= grid_pkg::IDLE;
      cnt   <= '0;
      row   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      row   <= row_n;
    end
  end

  // Scan sequencing; enable is only looked at in IDLE and at the end of a whole frame
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    row_n     = row;
    frame_end = 1'b0;
    swap_ok   = 1'b0;
    unique case (state)
      grid_pkg::IDLE: begin
        swap_ok = 1'b1;
        cnt_n   = '0;
        row_n   = '0;
        if (enable) state_n = grid_pkg::BLANK;
      end
      grid_pkg::BLANK: begin
        if (cnt == BLANK_LAST) begin
          cnt_n   = '0;
          state_n = grid_pkg::DRIVE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      grid_pkg::DRIVE: begin
        if (cnt == DWELL_LAST) begin
          cnt_n = '0;
          if (row != ROW_LAST) begin
            row_n   = row + ROW_W'(1);
            state_n = grid_pkg::BLANK;
          end else begin
            frame_end = 1'b1;
            swap_ok   = 1'b1;
            row_n     = '0;
            state_n   = enable ? grid_pkg::BLANK : grid_pkg::IDLE;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = grid_pkg::IDLE;
    endcase
  end

  // Pin registers: row and column drive update on the same edge, dark outside DRIVE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_sel    <= '0;
      col_data   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (state == grid_pkg::DRIVE) begin
        row_sel  <= row_onehot(row);
        col_data <= row_slice(display, row);
      end else begin
        row_sel  <= '0;
        col_data <= '0;
      end
    end
  end

endmodule

// File: tb/tb_grid_scan.sv
// tb/tb_grid_scan.sv - self-checking bench for grid_scan
module tb_grid_scan;
  import grid_pkg::*;

  localparam int          T_DWELL = 4;
  localparam int          T_BLANK = 1;
  localparam int          T_SLOT  = T_DWELL + T_BLANK;
  localparam int          T_FRAME = ROWS * T_SLOT;
  localparam logic [15:0] T_GMAX  = 16'd6;

  logic            clk = 1'b0;
  logic            reset;
  logic            enable;
  logic [ROWS-1:0] row_sel;
  logic [COLS-1:0] col_data;
  logic            frame_done;
  logic [15:0]     gen_count;

  grid_scan_if gif ();

  grid_scan #(.DWELL(T_DWELL), .BLANK(T_BLANK), .GEN_MAX(T_GMAX)) dut (
    .clk        (clk),
    .reset      (reset),
    .gif        (gif),
    .enable     (enable),
    .row_sel    (row_sel),
    .col_data   (col_data),
    .frame_done (frame_done),
    .gen_count  (gen_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          row;
    logic [15:0] rs;
    logic [15:0] cd;
  } vec_t;

  int vectors     = 0;
  int miscompares = 0;

  // reference model: buffers as plain values, updated per accepted transfer / swap event
  grid_t       m_pend;
  grid_t       m_disp;
  bit          m_full;
  logic [15:0] m_gen;

  logic [15:0] cap_rs [ROWS];
  logic [15:0] cap_cd [ROWS];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [COLS-1:0] exp_row(input grid_t g, input int r);
    grid_t s;
    s = g >> ((ROWS - 1 - r) * COLS);
    return s[COLS-1:0];
  endfunction

  function automatic grid_t rand_grid();
    grid_t g;
    for (int i = 0; i < ROWS*COLS/32; i++) g[i*32 +: 32] = $urandom;
    return g;
  endfunction

  task automatic m_reset();
    m_pend = '0;
    m_disp = '0;
    m_full = 1'b0;
    m_gen  = 16'd0;
  endtask

  task automatic m_swap();
    if (m_full) begin
      m_disp = m_pend;
      m_full = 1'b0;
      m_gen  = (m_gen == T_GMAX) ? 16'd0 : m_gen + 16'd1;
    end
  endtask

  // one clock while the scanner sits in IDLE (or leaves it on this edge)
  task automatic idle_step(input bit v, input grid_t d, input string tag);
    bit acc;
    gif.grid_valid = v;
    gif.grid_in    = d;
    acc = v && !m_full;
    tick();
    m_swap();
    if (acc) begin
      m_pend = d;
      m_full = 1'b1;
    end
    gif.grid_valid = 1'b0;
    chk({tag, " row_sel"}, row_sel, 0);
    chk({tag, " col_data"}, col_data, 0);
    chk({tag, " frame_done"}, frame_done, 0);
    chk({tag, " grid_ready"}, gif.grid_ready, !m_full);
    chk({tag, " gen_count"}, gen_count, m_gen);
  endtask

  // scan one frame (cycles 1..stop_c after the frame start edge) checking every cycle
  task automatic run_frame(input int load_c, input grid_t load_d, input int load_c2,
                           input int drop_c, input int rnd_pct, input int stop_c,
                           input string tag);
    grid_t fdisp;
    fdisp = m_disp;
    for (int c = 1; c <= stop_c; c++) begin
      bit    v;
      bit    acc;
      grid_t d;
      int    k, r, ph;
      v = 1'b0;
      d = '0;
      if (c == load_c) begin
        v = 1'b1;
        d = load_d;
      end else if (c == load_c2 || (rnd_pct > 0 && $urandom_range(99) < rnd_pct)) begin
        v = 1'b1;
        d = rand_grid();
      end
      if (c == drop_c) enable = 1'b0;
      gif.grid_valid = v;
      gif.grid_in    = d;
      acc = v && !m_full;
      tick();
      if (c == T_FRAME) m_swap();
      if (acc) begin
        m_pend = d;
        m_full = 1'b1;
      end
      gif.grid_valid = 1'b0;
      k  = c - 1;
      r  = k / T_SLOT;
      ph = k % T_SLOT;
      if (ph < T_BLANK) begin
        chk({tag, " row_sel blank"}, row_sel, 0);
        chk({tag, " col_data blank"}, col_data, 0);
      end else begin
        chk({tag, " row_sel"}, row_sel, 32'(16'h0001 << r));
        chk({tag, " col_data"}, col_data, exp_row(fdisp, r));
        if (ph == T_BLANK) begin
          cap_rs[r] = row_sel;
          cap_cd[r] = col_data;
        end
      end
      chk({tag, " frame_done"}, frame_done, (c == T_FRAME));
      chk({tag, " grid_ready"}, gif.grid_ready, !m_full);
      chk({tag, " gen_count"}, gen_count, m_gen);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t        tbl [ROWS];
    logic [15:0] pat [4];
    grid_t       p_grid;
    grid_t       q_grid;
    int          guard;

    pat[0] = 16'h0412;
    pat[1] = 16'h6424;
    pat[2] = 16'h0034;
    pat[3] = 16'h3C28;
    for (int r = 0; r < ROWS; r++) begin
      tbl[r].row = r;
      tbl[r].rs  = 16'h0001 << r;
      tbl[r].cd  = pat[r % 4];
    end
    for (int i = 0; i < 4; i++) p_grid[i*64 +: 64] = 64'h0412_6424_0034_3C28;
    q_grid = '1;

    reset          = 1'b0;
    enable         = 1'b0;
    gif.grid_valid = 1'b0;
    gif.grid_in    = '0;
    m_reset();

    // reset state
    tick();
    tick();
    chk("rst row_sel", row_sel, 0);
    chk("rst col_data", col_data, 0);
    chk("rst frame_done", frame_done, 0);
    chk("rst gen_count", gen_count, 0);
    chk("rst grid_ready", gif.grid_ready, 1);
    reset = 1'b1;
    idle_step(1'b0, '0, "idle0");

    // load P in IDLE: ready drops, swap on the next edge, ready back
    idle_step(1'b1, p_grid, "loadP");
    chk("loadP ready low", gif.grid_ready, 0);
    idle_step(1'b0, '0, "swapP");
    chk("swapP gen", gen_count, 16'd1);
    chk("swapP ready high", gif.grid_ready, 1);
    idle_step(1'b0, '0, "idleP");

    // first frame of P, table check per row
    enable = 1'b1;
    idle_step(1'b0, '0, "startP");
    run_frame(-1, '0, -1, 0, 0, T_FRAME, "frameP");
    for (int i = 0; i < ROWS; i++) begin
      chk($sformatf("tblP row%0d row_sel", tbl[i].row), cap_rs[tbl[i].row], tbl[i].rs);
      chk($sformatf("tblP row%0d col_data", tbl[i].row), cap_cd[tbl[i].row], tbl[i].cd);
    end

    // Q loaded mid-frame; a second valid while full is ignored
    run_frame(20, q_grid, 40, 0, 0, T_FRAME, "frameP_loadQ");
    chk("afterQ gen", gen_count, 16'd2);
    run_frame(-1, '0, -1, 0, 0, T_FRAME, "frameQ");
    chk("frameQ row9 col", cap_cd[9], 16'hFFFF);

    // randomized loads across several frames
    for (int f = 0; f < 4; f++) run_frame(-1, '0, -1, 0, 8, T_FRAME, $sformatf("rand%0d", f));

    // enable dropped during row 7: frame completes, then IDLE
    run_frame(-1, '0, -1, 7*T_SLOT + 2, 0, T_FRAME, "drop");
    for (int i = 0; i < 3; i++) idle_step(1'b0, '0, "idle_after_drop");

    // reset during DRIVE of row 5 with a generation pending
    enable = 1'b1;
    idle_step(1'b0, '0, "startR");
    run_frame(10, q_grid, -1, 0, 0, 5*T_SLOT + T_BLANK + 2, "preR");
    chk("preR pending held", gif.grid_ready, 0);
    reset = 1'b0;
    #1;
    m_reset();
    chk("midrst row_sel", row_sel, 0);
    chk("midrst col_data", col_data, 0);
    chk("midrst grid_ready", gif.grid_ready, 1);
    chk("midrst gen_count", gen_count, 0);
    tick();
    tick();
    chk("midrst hold row_sel", row_sel, 0);
    reset = 1'b1;
    idle_step(1'b0, '0, "startBlankData");
    run_frame(-1, '0, -1, 50, 0, T_FRAME, "blankData");
    chk("blankData row5 row_sel", cap_rs[5], 16'h0020);
    chk("blankData row5 col", cap_cd[5], 16'h0000);

    // generation counter wrap
    idle_step(1'b0, '0, "wrap_idle");
    guard = 0;
    while (m_gen != T_GMAX && guard < 20) begin
      idle_step(1'b1, rand_grid(), "wrap_load");
      idle_step(1'b0, '0, "wrap_swap");
      guard++;
    end
    chk("wrap reached max", gen_count, T_GMAX);
    idle_step(1'b1, rand_grid(), "wrap_last_load");
    idle_step(1'b0, '0, "wrap_last_swap");
    chk("wrap to zero", gen_count, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
